// File: rtl/fb_write_sched_if.sv
// fb_write_sched_if: requester and memory-side bundle for the framebuffer
// write scheduler.
//   paint  : p_wr0, p_wr1, p_addr, p_wdata  (unstallable strobes)
//   loader : ld_valid, ld_ready, ld_addr (MSB = bank), ld_wdata
//   clear  : clear_start, clear_color, clear_busy, clear_done
//   memory : m_wr0, m_wr1, m_addr, m_wdata
//   status : stall_cnt
// Modport slave is the scheduler; modport master is the requester/memory side.
interface fb_write_sched_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 12
);
  logic              p_wr0;
  logic              p_wr1;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic              m_wr0;
  logic              m_wr1;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [15:0]       stall_cnt;

  modport slave (
    input  p_wr0, p_wr1, p_addr, p_wdata,
    input  ld_valid, ld_addr, ld_wdata,
    output ld_ready,
    input  clear_start, clear_color,
    output clear_busy, clear_done,
    output m_wr0, m_wr1, m_addr, m_wdata,
    output stall_cnt
  );

  modport master (
    output p_wr0, p_wr1, p_addr, p_wdata,
    output ld_valid, ld_addr, ld_wdata,
    input  ld_ready,
    output clear_start, clear_color,
    input  clear_busy, clear_done,
    input  m_wr0, m_wr1, m_addr, m_wdata,
    input  stall_cnt
  );
endinterface

// File: rtl/fb_write_sched.sv
// fb_write_sched: shares the single framebuffer write port between the paint
// controller, a streaming loader and an internal clear engine.
// Fixed priority paint > loader > clear; all memory-side outputs registered
// with one cycle of latency.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - fb_write_sched_if.slave (requesters, memory write port, status)
// Optional feature: define FBW_STALL_CNT_EN to build the saturating loader
// stall counter on stall_cnt; otherwise stall_cnt is tied to zero.
module fb_write_sched #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CLEAR_DEPTH = 2048
) (
  input  logic             clk,
  input  logic             rst,
  fb_write_sched_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(CLEAR_DEPTH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] color_q;
  logic              busy_q;
  logic              done_q;
  logic              m_wr0_q;
  logic              m_wr1_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;

  logic paint_req;
  logic ld_ready;
  logic ld_xfer;
  logic clr_grant;
  logic clr_last;
  logic start_acc;

  always_comb begin
    paint_req = bus.p_wr0 | bus.p_wr1;
    ld_ready  = ~rst & ~paint_req;
    ld_xfer   = bus.ld_valid & ld_ready;
    clr_grant = (state_q == SWEEP) & ~paint_req & ~ld_xfer;
    clr_last  = clr_grant & (ptr_q == LAST_PTR);
    // A start landing on the final clear write chains straight into a new
    // sweep so clear_busy never drops.
    start_acc = bus.clear_start & ((state_q == IDLE) | clr_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_wr0_q   <= 1'b0;
      m_wr1_q   <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      m_wr0_q <= 1'b0;
      m_wr1_q <= 1'b0;
      done_q  <= 1'b0;

      // Address/data hold their previous value when nothing is granted.
      if (paint_req) begin
        m_wr0_q   <= bus.p_wr0;
        m_wr1_q   <= bus.p_wr1;
        m_addr_q  <= bus.p_addr;
        m_wdata_q <= bus.p_wdata;
      end else if (ld_xfer) begin
        m_wr0_q   <= ~bus.ld_addr[ADDR_W];
        m_wr1_q   <= bus.ld_addr[ADDR_W];
        m_addr_q  <= bus.ld_addr[ADDR_W-1:0];
        m_wdata_q <= bus.ld_wdata;
      end else if (clr_grant) begin
        m_wr0_q   <= 1'b1;
        m_wr1_q   <= 1'b1;
        m_addr_q  <= ptr_q;
        m_wdata_q <= color_q;
      end

      case (state_q)
        IDLE: begin
          if (start_acc) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            color_q <= bus.clear_color;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (clr_grant) begin
            if (clr_last) begin
              done_q <= 1'b1;
              ptr_q  <= '0;
              if (start_acc) begin
                color_q <= bus.clear_color;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.clear_busy = busy_q;
  assign bus.clear_done = done_q;
  assign bus.m_wr0      = m_wr0_q;
  assign bus.m_wr1      = m_wr1_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_wdata    = m_wdata_q;

`ifdef FBW_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_q <= '0;
    end else if (bus.ld_valid && !ld_ready && stall_q != '1) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_write_sched.sv
module tb_fb_write_sched;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  fb_write_sched_if #(.ADDR_W(11), .DATA_W(12)) bus ();

  fb_write_sched #(
    .ADDR_W(11),
    .DATA_W(12),
    .CLEAR_DEPTH(2048)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {wr0, wr1, addr, wdata, done, busy}
  function automatic logic [63:0] pk(input logic w0, input logic w1, input logic [10:0] a,
                                     input logic [11:0] d, input logic dn, input logic bz);
    return 64'({w0, w1, a, d, dn, bz});
  endfunction

  initial begin
    int unsigned clr_writes, busy_cycles, done_cnt, color_err, order_err, paint_seen;
    logic [10:0] exp_ptr;

    rst             = 1'b1;
    bus.p_wr0       = 1'b0;
    bus.p_wr1       = 1'b0;
    bus.p_addr      = '0;
    bus.p_wdata     = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_wdata    = '0;
    bus.clear_start = 1'b0;
    bus.clear_color = '0;

    // Reset state
    tick(); tick();
    chk("reset_outputs", pk(bus.m_wr0, bus.m_wr1, bus.m_addr, bus.m_wdata, bus.clear_done, bus.clear_busy),
        pk(0, 0, 11'h000, 12'h000, 0, 0));
    chk("reset_ld_ready", 64'(bus.ld_ready), 64'd0);
    chk("reset_stall", 64'(bus.stall_cnt), 64'd0);
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_outputs", pk(bus.m_wr0, bus.m_wr1, bus.m_addr, bus.m_wdata, bus.clear_done, bus.clear_busy),
        pk(0, 0, 11'h000, 12'h000, 0, 0));
    chk("idle_ld_ready", 64'(bus.ld_ready), 64'd1);
    chk("idle_stall", 64'(bus.stall_cnt), 64'd0);

    // Paint beats a simultaneous loader request; loader follows one cycle later
    bus.p_wr1    = 1'b1;
    bus.p_addr   = 11'h123;
    bus.p_wdata  = 12'hF00;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 12'h456;
    bus.ld_wdata = 12'h555;
    #1;
    chk("paint_blocks_ld_ready", 64'(bus.ld_ready), 64'd0);
    tick();
    bus.p_wr1 = 1'b0;
    #1;
    chk("paint_grant", pk(bus.m_wr0, bus.m_wr1, bus.m_addr, bus.m_wdata, 0, 0),
        pk(0, 1, 11'h123, 12'hF00, 0, 0));
    chk("ld_ready_after_paint", 64'(bus.ld_ready), 64'd1);
    tick();
    bus.ld_valid = 1'b0;
    chk("loader_grant_bank0", pk(bus.m_wr0, bus.m_wr1, bus.m_addr, bus.m_wdata, 0, 0),
        pk(1, 0, 11'h456, 12'h555, 0, 0));
    tick();
    chk("no_grant_holds", pk(bus.m_wr0, bus.m_wr1, bus.m_addr, bus.m_wdata, 0, 0),
        pk(0, 0, 11'h456, 12'h555, 0, 0));

    // Loader burst into bank 1
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 12'h800 + 12'(i);
      bus.ld_wdata = 12'h0A0;
      tick();
      chk($sformatf("burst_%0d", i), pk(bus.m_wr0, bus.m_wr1, bus.m_addr, bus.m_wdata, 0, 0),
          pk(0, 1, 11'(i), 12'h0A0, 0, 0));
    end
    bus.ld_valid = 1'b0;
    tick();
    chk("burst_end_idle", 64'({bus.m_wr0, bus.m_wr1}), 64'd0);

    // Uncontended full sweep
    bus.clear_start = 1'b1;
    bus.clear_color = 12'h00F;
    tick();
    bus.clear_start = 1'b0;
    chk("sweep_start", pk(bus.m_wr0, bus.m_wr1, 0, 0, bus.clear_done, bus.clear_busy),
        pk(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 2048; i++) begin
      tick();
      chk($sformatf("sweep_%0d", i),
          pk(bus.m_wr0, bus.m_wr1, bus.m_addr, bus.m_wdata, bus.clear_done, bus.clear_busy),
          pk(1, 1, 11'(i), 12'h00F, (i == 2047), (i != 2047)));
    end
    tick();
    chk("sweep_after", pk(bus.m_wr0, bus.m_wr1, 0, 0, bus.clear_done, bus.clear_busy),
        pk(0, 0, 0, 0, 0, 0));

    // Contended sweep: 5 paint cycles and an ignored second clear_start
    bus.clear_start = 1'b1;
    bus.clear_color = 12'h00F;
    tick();
    bus.clear_start = 1'b0;
    clr_writes  = 0;
    busy_cycles = bus.clear_busy ? 1 : 0;
    done_cnt    = 0;
    color_err   = 0;
    order_err   = 0;
    paint_seen  = 0;
    exp_ptr     = '0;
    for (int c = 0; c < 2200; c++) begin
      bus.p_wr0       = (c == 5 || c == 100 || c == 500 || c == 1000 || c == 2000);
      bus.p_addr      = 11'h7FF;
      bus.p_wdata     = 12'h111;
      bus.clear_start = (c == 50);
      bus.clear_color = (c == 50) ? 12'hABC : 12'h00F;
      tick();
      if (bus.m_wr0 && bus.m_wr1) begin
        clr_writes++;
        if (bus.m_wdata !== 12'h00F) color_err++;
        if (bus.m_addr !== exp_ptr) order_err++;
        exp_ptr = exp_ptr + 11'd1;
      end
      if (bus.m_wr0 && !bus.m_wr1 && bus.m_addr === 11'h7FF) paint_seen++;
      if (bus.clear_done) done_cnt++;
      if (bus.clear_busy) busy_cycles++;
    end
    bus.p_wr0       = 1'b0;
    bus.clear_start = 1'b0;
    chk("contended_clear_writes", 64'(clr_writes), 64'd2048);
    chk("contended_busy_cycles", 64'(busy_cycles), 64'd2053);
    chk("contended_done_count", 64'(done_cnt), 64'd1);
    chk("contended_color_err", 64'(color_err), 64'd0);
    chk("contended_order_err", 64'(order_err), 64'd0);
    chk("contended_paint_seen", 64'(paint_seen), 64'd5);

    // Reset mid-sweep aborts without a done pulse
    bus.clear_start = 1'b1;
    bus.clear_color = 12'h0F0;
    tick();
    bus.clear_start = 1'b0;
    repeat (10) tick();
    chk("midsweep_addr", 64'(bus.m_addr), 64'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midsweep_reset", pk(bus.m_wr0, bus.m_wr1, bus.m_addr, bus.m_wdata, bus.clear_done, bus.clear_busy),
        pk(0, 0, 0, 0, 0, 0));
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.clear_done || bus.clear_busy || bus.m_wr0 || bus.m_wr1) done_cnt++;
    end
    chk("midsweep_quiet", 64'(done_cnt), 64'd0);

    // Loader stalled behind continuous paint writes
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 12'h001;
    bus.p_wr0    = 1'b1;
    bus.p_addr   = 11'h010;
    repeat (20) tick();
    chk("stall_ld_ready", 64'(bus.ld_ready), 64'd0);
`ifdef FBW_STALL_CNT_EN
    chk("stall_cnt_20", 64'(bus.stall_cnt), 64'd20);
    repeat (69980) tick();
    chk("stall_cnt_sat", 64'(bus.stall_cnt), 64'hFFFF);
`else
    chk("stall_cnt_tied", 64'(bus.stall_cnt), 64'd0);
`endif
    bus.ld_valid = 1'b0;
    bus.p_wr0    = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
Name: fb_write_sched

Overview:
- Write-port scheduler for the dual-bank framebuffer. Bank 0 holds the upper half-screen and bank 1 the lower; each bank has 2048 words of 12 bits.
- It shares the single memory write port between three requesters:
  - the paint controller (cursor/brush writes, which cannot be stalled);
  - a streaming image loader with a valid/ready handshake;
  - an internal clear engine that sweeps every address with a fill colour.
- It sits between those requesters and the framebuffer memory write inputs. All memory-side outputs are registered.

Parameters:
- ADDR_W, 11, word address width per bank.
- DATA_W, 12, pixel data width (4:4:4 RGB).
- CLEAR_DEPTH, 2048, number of addresses swept by the clear engine (must be ≤ 2^ADDR_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- p_wr0  in  1  paint write strobe, bank 0.
- p_wr1  in  1  paint write strobe, bank 1.
- p_addr  in  ADDR_W  paint write address.
- p_wdata  in  DATA_W  paint write data.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted this cycle (combinational).
- ld_addr  in  ADDR_W+1  loader address; MSB is bank select (0 = bank 0).
- ld_wdata  in  DATA_W  loader data.
- clear_start  in  1  one-cycle pulse that starts a full-screen clear.
- clear_color  in  DATA_W  fill colour, sampled on an accepted clear_start.
- clear_busy  out  1  clear sweep in progress.
- clear_done  out  1  one-cycle pulse after the final clear write issues.
- m_wr0  out  1  memory write strobe, bank 0.
- m_wr1  out  1  memory write strobe, bank 1.
- m_addr  out  ADDR_W  memory write address.
- m_wdata  out  DATA_W  memory write data.
- stall_cnt  out  16  loader stall counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge clk):
  - m_wr0, m_wr1, m_addr, m_wdata, clear_busy, clear_done, stall_cnt all go to 0.
  - Clear pointer goes to 0; state goes to IDLE.
  - Reset mid-sweep aborts the clear with no clear_done pulse.
- Fixed priority per cycle: paint > loader > clear.
  - paint_req = p_wr0 | p_wr1.
  - ld_ready = ~rst & ~paint_req. It does not depend on ld_valid.
  - A loader transfer occurs when ld_valid & ld_ready.
  - The clear engine issues a write only when clear_busy and there is neither a paint request nor a loader transfer.
- Output latency: exactly 1 cycle. The winning request at edge N appears on m_* after edge N, for one cycle only.
  - Paint grant: m_wr0=p_wr0, m_wr1=p_wr1, m_addr=p_addr, m_wdata=p_wdata. Both strobes may be set together.
  - Loader grant: m_wr0=~ld_addr[ADDR_W], m_wr1=ld_addr[ADDR_W], m_addr=ld_addr[ADDR_W-1:0], m_wdata=ld_wdata.
  - Clear grant: m_wr0=m_wr1=1, m_addr=clear pointer, m_wdata=latched clear_color.
  - No grant: m_wr0=m_wr1=0. m_addr and m_wdata hold their previous values.
- State machine:
  - IDLE → SWEEP on clear_start. This latches clear_color, sets the pointer to 0, and sets clear_busy on the next cycle.
  - In SWEEP, each clear grant increments the pointer.
  - A clear grant with pointer = CLEAR_DEPTH-1 goes to IDLE. It clears clear_busy and pulses clear_done for one cycle, aligned with the last clear write on m_*.
  - A cycle with no clear grant holds the pointer. There is no skip and no wrap.
- clear_start while clear_busy is ignored (no restart, colour unchanged).
- clear_start in the same cycle as clear_done is accepted: a new sweep starts with clear_busy staying high.
- Paint and loader writes during a sweep take effect immediately. They may later be overwritten by the sweep if they land at addresses not yet swept.
- Pointer width is ADDR_W; the sweep never exceeds CLEAR_DEPTH-1.
- Sweep duration is CLEAR_DEPTH cycles with no contention, plus one cycle per contended cycle.

Optional Feature:
- Macro: FBW_STALL_CNT_EN.
- Defined:
  - stall_cnt is a 16-bit saturating counter, incremented each cycle with ld_valid & ~ld_ready, holding at 16'hFFFF.
  - It is cleared by rst and by an accepted clear_start.
- Not defined: stall_cnt is tied to 16'h0000 and no counter logic is synthesized.

Test Plan:
- Reset, then idle for 10 cycles → m_wr0=m_wr1=0, ld_ready=1, clear_busy=0, stall_cnt=0.
- Paint write p_wr1=1, p_addr=11'h123, p_wdata=12'hF00, with ld_valid=1 in the same cycle → ld_ready=0 that cycle. The next cycle shows m_wr1=1, m_wr0=0, m_addr=11'h123, m_wdata=12'hF00. The loader transfer completes one cycle later.
- Loader burst of 4 with ld_addr=12'h800..12'h803 and data 12'h0A0 → four consecutive cycles with m_wr1=1, m_addr=0..3, m_wdata=12'h0A0, each 1 cycle after acceptance.
- clear_start with clear_color=12'h00F and no contention → 2048 cycles of m_wr0=m_wr1=1 with m_addr 0..2047. clear_done pulses once with m_addr=2047, then clear_busy=0.
- During a sweep, inject paint writes on 5 cycles and a second clear_start → the sweep takes 2053 cycles, the colour stays 12'h00F, and there is exactly one clear_done.
- With FBW_STALL_CNT_EN defined, hold ld_valid=1 while p_wr0=1 for 70000 cycles → stall_cnt=16'hFFFF. Without the macro, stall_cnt=0.
